// File: rtl/dom_sub_nibbles.sv
// rtl/dom_sub_nibbles.sv - serial two-share DOM SubNibbles layer with one shared S-box
//
// domSBoxNoR: unregistered two-share DOM S-box for the small-scale AES 4-bit S-box
// (inversion in GF(2^4) mod x^4+x+1, then affine map with constant 6).
//   i_a, i_b       share a / share b of the input nibble
//   i_r_bits[11:0] fresh randomness: [3:0] refresh of x^2, [7:4] and [11:8] DOM cross terms
//   o_aq, o_bq     share a / share b of S(i_a ^ i_b)
//
// dom_sub_nibbles: pushes one nibble per cycle of a masked state through domSBoxNoR.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input state handshake, in_a/in_b are the two input shares
//   rnd/rnd_valid/rnd_ack  12-bit randomness per nibble, consumed when rnd_ack=1
//   out_valid/out_ready output state handshake, out_a/out_b are the two output shares
// Optional feature macro: DOM_SUBNIB_ZEROIZE_EN clears all share registers on the
// output handshake.

module domSBoxNoR (
  input  logic [3:0]  i_a,
  input  logic [3:0]  i_b,
  input  logic [11:0] i_r_bits,
  output logic [3:0]  o_aq,
  output logic [3:0]  o_bq
);

  // Squaring is linear in GF(2^4), so it is applied to each share independently.
  function automatic logic [3:0] gf_sq(input logic [3:0] x);
    return {x[3], x[1] ^ x[3], x[2], x[0] ^ x[2]};
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // Linear part of the affine output map; the constant is added on share a only.
  function automatic logic [3:0] lin(input logic [3:0] y);
    return {y[0] ^ y[1] ^ y[3], y[0] ^ y[2] ^ y[3], y[1] ^ y[2] ^ y[3], y[0] ^ y[1] ^ y[2]};
  endfunction

  logic [3:0] w_a2, w_b2, w_a3, w_b3, w_a12, w_b12, w_a14, w_b14;

  // x^-1 = x^14 = (x * x^2)^4 * x^2; each product is a DOM multiplier whose
  // cross-domain terms are blinded with their own 4 random bits.
  assign w_a2  = gf_sq(i_a) ^ i_r_bits[3:0];
  assign w_b2  = gf_sq(i_b) ^ i_r_bits[3:0];
  assign w_a3  = gf_mul(i_a, w_a2) ^ (gf_mul(i_a, w_b2) ^ i_r_bits[7:4]);
  assign w_b3  = gf_mul(i_b, w_b2) ^ (gf_mul(i_b, w_a2) ^ i_r_bits[7:4]);
  assign w_a12 = gf_sq(gf_sq(w_a3));
  assign w_b12 = gf_sq(gf_sq(w_b3));
  assign w_a14 = gf_mul(w_a12, w_a2) ^ (gf_mul(w_a12, w_b2) ^ i_r_bits[11:8]);
  assign w_b14 = gf_mul(w_b12, w_b2) ^ (gf_mul(w_b12, w_a2) ^ i_r_bits[11:8]);
  assign o_aq  = lin(w_a14) ^ 4'h6;
  assign o_bq  = lin(w_b14);

endmodule

module dom_sub_nibbles #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic [11:0]            rnd,
  input  logic                   rnd_valid,
  output logic                   rnd_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_a,
  output logic [4*NIBBLES-1:0]   out_b
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_in_a, r_in_b, r_out_a, r_out_b;
  logic [3:0]        w_nib_a, w_nib_b, w_aq, w_bq;
  logic              w_accept, w_write;

  // Current nibble of each share, selected independently so shares never meet.
  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == i[IDXW-1:0]) begin
        w_nib_a = r_in_a[i*4 +: 4];
        w_nib_b = r_in_b[i*4 +: 4];
      end
    end
  end

  domSBoxNoR u_sbox (
    .i_a      (w_nib_a),
    .i_b      (w_nib_b),
    .i_r_bits (rnd),
    .o_aq     (w_aq),
    .o_bq     (w_bq)
  );

  // rnd_ack depends on control state and rnd_valid only, never on share data.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    rnd_ack     = 1'b0;
    w_accept    = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (rnd_valid) begin
          rnd_ack = 1'b1;
          w_write = 1'b1;
          if (r_idx == IDXW'(NIBBLES - 1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_in_a  <= '0;
      r_in_b  <= '0;
      r_out_a <= '0;
      r_out_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_in_a <= in_a;
        r_in_b <= in_b;
        r_idx  <= '0;
      end
      if (w_write) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (r_idx == i[IDXW-1:0]) begin
            r_out_a[i*4 +: 4] <= w_aq;
            r_out_b[i*4 +: 4] <= w_bq;
          end
        end
        r_idx <= r_idx + IDXW'(1);
      end
`ifdef DOM_SUBNIB_ZEROIZE_EN
      // Wipe every share register as the result is handed over.
      if (r_state == S_DONE && out_ready) begin
        r_in_a  <= '0;
        r_in_b  <= '0;
        r_out_a <= '0;
        r_out_b <= '0;
      end
`endif
    end
  end

  assign out_a = r_out_a;
  assign out_b = r_out_b;

endmodule

// File: tb/tb_dom_sub_nibbles.sv
// tb/tb_dom_sub_nibbles.sv - directed self-checking bench for dom_sub_nibbles
module tb_dom_sub_nibbles;

  logic        clk, rst_n, in_valid, in_ready, rnd_valid, rnd_ack, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_a, out_b;
  logic [11:0] rnd;
  int          n_cmp, n_bad;

  dom_sub_nibbles #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers one state and feeds randomness until out_valid (bounded). lat counts the
  // accept edge as 1; stall_n cycles of rnd_valid=0 are inserted after the 2nd nibble.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input int stall_n,
                         output int lat, output int acks, output int stall_acks);
    int left;
    left = stall_n; acks = 0; stall_acks = 0;
    in_a = a; in_b = b; in_valid = 1'b1; rnd_valid = 1'b0; rnd = 12'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      rnd = 12'($urandom);
      if (acks == 2 && left > 0) begin rnd_valid = 1'b0; left--; end
      else rnd_valid = 1'b1;
      #1;
      if (rnd_ack === 1'b1) begin
        acks++;
        if (rnd_valid == 1'b0) stall_acks++;
      end
      @(posedge clk); #1;
      lat++;
    end
    rnd_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b1; rnd = 12'hABC;
    in_a = 16'h0; in_b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (rnd_ack !== 1'b0) begin n_bad++; $display("FAIL reset_rnd_ack got=%b want=0", rnd_ack); end
    n_cmp++; if (out_a !== 16'h0) begin n_bad++; $display("FAIL reset_out_a got=%h want=0000", out_a); end
    n_cmp++; if (out_b !== 16'h0) begin n_bad++; $display("FAIL reset_out_b got=%h want=0000", out_b); end
    rst_n = 1'b1; rnd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_smoke();
    int lat, acks, sa;
    run_one(16'h0123, 16'h0000, 0, lat, acks, sa);
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL smoke_latency got=%0d want=5", lat); end
    n_cmp++; if ((out_a ^ out_b) !== 16'h6B54) begin n_bad++; $display("FAIL smoke_result got=%h want=6b54", out_a ^ out_b); end
    n_cmp++; if (acks != 4) begin n_bad++; $display("FAIL smoke_acks got=%0d want=4", acks); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL smoke_in_ready_done got=%b want=0", in_ready); end
    handshake();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL smoke_back_idle got=%b want=1", in_ready); end
  endtask

  task automatic test_masked();
    int lat, acks, sa, hits;
    logic [15:0] m;
    run_one(16'hA4E0, 16'hA5C3, 0, lat, acks, sa);
    n_cmp++; if ((out_a ^ out_b) !== 16'h6B54) begin n_bad++; $display("FAIL masked_result got=%h want=6b54", out_a ^ out_b); end
    handshake();
    run_one(16'hFFFF, 16'h0000, 0, lat, acks, sa);
    n_cmp++; if ((out_a ^ out_b) !== 16'h8888) begin n_bad++; $display("FAIL masked_ffff got=%h want=8888", out_a ^ out_b); end
    handshake();
    hits = 0;
    for (int k = 0; k < 1000; k++) begin
      m = 16'($urandom);
      run_one(16'h0123 ^ m, m, 0, lat, acks, sa);
      n_cmp++; if ((out_a ^ out_b) !== 16'h6B54) begin n_bad++; $display("FAIL masked_run%0d got=%h want=6b54", k, out_a ^ out_b); end
      if (out_a === 16'h6B54) hits++;
      handshake();
    end
    n_cmp++; if (hits >= 1000) begin n_bad++; $display("FAIL masked_share_leak hits=%0d want<1000", hits); end
  endtask

  task automatic test_stall();
    int lat, acks, sa;
    run_one(16'hA4E0, 16'hA5C3, 3, lat, acks, sa);
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL stall_latency got=%0d want=8", lat); end
    n_cmp++; if (acks != 4) begin n_bad++; $display("FAIL stall_acks got=%0d want=4", acks); end
    n_cmp++; if (sa != 0) begin n_bad++; $display("FAIL stall_ack_during_stall got=%0d want=0", sa); end
    n_cmp++; if ((out_a ^ out_b) !== 16'h6B54) begin n_bad++; $display("FAIL stall_result got=%h want=6b54", out_a ^ out_b); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat, acks, sa;
    logic [15:0] ha, hb;
    run_one(16'h1234 ^ 16'h5A5A, 16'h5A5A, 0, lat, acks, sa);
    ha = out_a; hb = out_b;
    // S: 1->B 2->5 3->4 4->2, so 1234 -> B542
    n_cmp++; if ((ha ^ hb) !== 16'hB542) begin n_bad++; $display("FAIL bp_result got=%h want=b542", ha ^ hb); end
    in_a = 16'hFFFF; in_b = 16'h0000; in_valid = 1'b1; rnd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid c%0d got=%b want=1", c, out_valid); end
      n_cmp++; if (out_a !== ha || out_b !== hb) begin n_bad++; $display("FAIL bp_stable c%0d got=%h/%h want=%h/%h", c, out_a, out_b, ha, hb); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d got=%b want=0", c, in_ready); end
    end
    in_valid = 1'b0; rnd_valid = 1'b0;
    handshake();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat, acks, sa;
    in_a = 16'h0123; in_b = 16'h0000; in_valid = 1'b1; rnd_valid = 1'b1; rnd = 12'h5A3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (rnd_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_rnd_ack got=%b want=0", rnd_ack); end
    n_cmp++; if (out_a !== 16'h0 || out_b !== 16'h0) begin n_bad++; $display("FAIL rstmid_outputs got=%h/%h want=0000/0000", out_a, out_b); end
    rnd_valid = 1'b0;
    run_one(16'hFFFF, 16'h0000, 0, lat, acks, sa);
    n_cmp++; if ((out_a ^ out_b) !== 16'h8888) begin n_bad++; $display("FAIL rstmid_next got=%h want=8888", out_a ^ out_b); end
    handshake();
  endtask

  task automatic test_zeroize();
    int lat, acks, sa;
    logic [15:0] ha, hb;
    run_one(16'h0123, 16'h0000, 0, lat, acks, sa);
    ha = out_a; hb = out_b;
    handshake();
`ifdef DOM_SUBNIB_ZEROIZE_EN
    n_cmp++; if (out_a !== 16'h0 || out_b !== 16'h0) begin n_bad++; $display("FAIL zeroize_cleared got=%h/%h want=0000/0000", out_a, out_b); end
`else
    n_cmp++; if ((out_a ^ out_b) !== 16'h6B54) begin n_bad++; $display("FAIL zeroize_retain got=%h want=6b54", out_a ^ out_b); end
    n_cmp++; if (out_a !== ha || out_b !== hb) begin n_bad++; $display("FAIL zeroize_hold got=%h/%h want=%h/%h", out_a, out_b, ha, hb); end
`endif
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0; rnd = 12'h0;
    in_a = 16'h0; in_b = 16'h0;
    test_reset();
    test_smoke();
    test_masked();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_zeroize();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
